// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction-fetch stage
package fetch_pkg;

   localparam int FETCH_XLEN = 32;

   localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [FETCH_XLEN-1:0] PC_STEP   = 32'd4;

   // One fetch-buffer slot: the PC is known at request time, the word arrives later.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
      logic                  filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular store of {pc, instr, filled} with alloc/fill/pop pointers
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          alloc_i,
   input  logic [FETCH_XLEN-1:0]         alloc_pc_i,
   input  logic                          fill_i,
   input  logic [FETCH_XLEN-1:0]         fill_instr_i,
   input  logic                          pop_i,
   output fetch_entry_t                  head_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic [$clog2(DEPTH):0]        unfilled_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   fetch_entry_t   entry_q [DEPTH];
   logic [PW-1:0]  alloc_ptr_q;
   logic [PW-1:0]  fill_ptr_q;
   logic [PW-1:0]  head_ptr_q;

   // head <= fill <= alloc always holds, so both differences are plain occupancies.
   assign count_o    = alloc_ptr_q - head_ptr_q;
   assign unfilled_o = alloc_ptr_q - fill_ptr_q;

   // Head view; a stale filled bit in an empty buffer must not leak out.
   always_comb begin
      head_o        = entry_q[head_ptr_q[AW-1:0]];
      head_o.filled = entry_q[head_ptr_q[AW-1:0]].filled && (count_o != '0);
   end

   // Alloc, fill and pop touch distinct slots whenever they are legal together.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else if (flush_i) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
      end else begin
         if (alloc_i) begin
            entry_q[alloc_ptr_q[AW-1:0]].pc     <= alloc_pc_i;
            entry_q[alloc_ptr_q[AW-1:0]].filled <= 1'b0;
            alloc_ptr_q                          <= alloc_ptr_q + PW'(1);
         end
         if (fill_i) begin
            entry_q[fill_ptr_q[AW-1:0]].instr  <= fill_instr_i;
            entry_q[fill_ptr_q[AW-1:0]].filled <= 1'b1;
            fill_ptr_q                          <= fill_ptr_q + PW'(1);
         end
         if (pop_i) begin
            head_ptr_q <= head_ptr_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_stage_buf.sv
// rtl/fetch_stage_buf.sv - PC generation, imem request/response handling and redirect discard
module fetch_stage_buf
   import fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_taken,
   input  logic [XLEN-1:0] alu_output,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            ValidF2D,
   input  logic            ReadyD2F,
   output logic [XLEN-1:0] InstrF2D,
   output logic [XLEN-1:0] PCF2D
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Entries are FETCH_XLEN wide, so XLEN is expected to equal FETCH_XLEN.
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count;
   logic [CW-1:0]   unfilled;
   logic [CW:0]     inflight;
   logic            req_fire;
   logic            rsp_fire;
   logic            rsp_fill;
   logic            pop;
   fetch_entry_t    head;

   // Buffered entries plus responses still owed to a flushed path share one cap.
   assign inflight       = {1'b0, count} + {1'b0, discard_q};
   assign imem_req_valid = rst && !br_taken && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_fire = rst && imem_rsp_valid;
   assign rsp_fill = rsp_fire && !br_taken && (discard_q == '0);

   assign ValidF2D = rst && head.filled && !br_taken;
   assign pop      = ValidF2D && ReadyD2F;
   assign InstrF2D = ValidF2D ? head.instr : XLEN'(NOP_INSTR);
   assign PCF2D    = ValidF2D ? head.pc : '0;

   // Redirect wins; otherwise step the PC on accept and retire one pending discard per response.
   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q;
      if (br_taken) begin
         pc_d      = {alu_output[XLEN-1:2], 2'b00};
         discard_d = discard_q + unfilled - CW'(rsp_fire);
      end else begin
         if (req_fire) begin
            pc_d = pc_q + XLEN'(PC_STEP);
         end
         if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
      end
   end

   // PC and discard counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   fetch_buffer #(
      .DEPTH (FIFO_DEPTH)
   ) u_buf (
      .clk_i        (clk),
      .rst_ni       (rst),
      .flush_i      (br_taken),
      .alloc_i      (req_fire),
      .alloc_pc_i   (pc_q),
      .fill_i       (rsp_fill),
      .fill_instr_i (imem_rsp_data),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .unfilled_o   (unfilled)
   );

   rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (({1'b0, discard_q} + {1'b0, unfilled}) != '0));

endmodule
